// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage program-counter sequencer.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } pc_state_e;

  localparam int unsigned DEFAULT_INSTR_BYTES = 4;

  // Low address bits that must be zero for an instruction-aligned target.
  function automatic int unsigned align_mask(input int unsigned instr_bytes);
    return instr_bytes - 1;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the core and the PC sequencer.
interface pc_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             Stall;
  logic             Redirect_valid;
  logic [WIDTH-1:0] Redirect_addr;
  logic             Trap;
  logic             Trap_return;
  logic [WIDTH-1:0] Pc_reg;
  logic             Pc_valid;
  logic [WIDTH-1:0] Epc;
  logic             Misaligned;

  modport master (
    output Stall, Redirect_valid, Redirect_addr, Trap, Trap_return,
    input  Pc_reg, Pc_valid, Epc, Misaligned
  );

  modport slave (
    input  Stall, Redirect_valid, Redirect_addr, Trap, Trap_return,
    output Pc_reg, Pc_valid, Epc, Misaligned
  );
endinterface

// File: rtl/pc_next_sel.sv
// Priority mux producing the next PC, EPC, state and misaligned flag.
//   state | meaning
//   BOOT  | first cycle after reset, inputs ignored, no fetch
//   RUN   | Pc_reg is a real fetch; advance or stall
//   FLUSH | one-cycle bubble after a control-flow change
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080,
  parameter int          INSTR_BYTES = DEFAULT_INSTR_BYTES
) (
  input  pc_state_e        state,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] epc,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_addr,
  input  logic             trap,
  input  logic             trap_return,
  output pc_state_e        state_next,
  output logic [WIDTH-1:0] pc_next,
  output logic [WIDTH-1:0] epc_next,
  output logic             misaligned_next
);
  localparam logic [WIDTH-1:0] TRAP_ADDR  = WIDTH'(TRAP_VECTOR);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(align_mask(INSTR_BYTES));
  localparam logic [WIDTH-1:0] STEP       = WIDTH'(INSTR_BYTES);

  logic redirect_misaligned;
  assign redirect_misaligned = |(redirect_addr & ALIGN_MASK);

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    epc_next        = epc;
    misaligned_next = 1'b0;
    if (state == BOOT) begin
      state_next = RUN;
    end else if (trap) begin
      epc_next   = pc;
      pc_next    = TRAP_ADDR;
      state_next = FLUSH;
    end else if (trap_return) begin
      pc_next    = epc;
      state_next = FLUSH;
    end else if (redirect_valid && redirect_misaligned) begin
      epc_next        = redirect_addr;
      pc_next         = TRAP_ADDR;
      misaligned_next = 1'b1;
      state_next      = FLUSH;
    end else if (redirect_valid) begin
      pc_next    = redirect_addr;
      state_next = FLUSH;
    end else if (state == RUN) begin
      if (!stall) pc_next = pc + STEP;
    end else begin
      state_next = RUN;
    end
  end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: registers only, next-state logic lives in pc_next_sel.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR  = '0,
  parameter logic [31:0]      TRAP_VECTOR = 32'h0000_0080,
  parameter int               INSTR_BYTES = DEFAULT_INSTR_BYTES
) (
  input logic           Clock,
  input logic           Reset,
  pc_sequencer_if.slave bus
);
  pc_state_e        state, state_next;
  logic [WIDTH-1:0] pc_q, pc_next;
  logic [WIDTH-1:0] epc_q, epc_next;
  logic             pc_valid_q;
  logic             misaligned_q, misaligned_next;

  pc_next_sel #(
    .WIDTH       (WIDTH),
    .TRAP_VECTOR (TRAP_VECTOR),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_next_sel (
    .state           (state),
    .pc              (pc_q),
    .epc             (epc_q),
    .stall           (bus.Stall),
    .redirect_valid  (bus.Redirect_valid),
    .redirect_addr   (bus.Redirect_addr),
    .trap            (bus.Trap),
    .trap_return     (bus.Trap_return),
    .state_next      (state_next),
    .pc_next         (pc_next),
    .epc_next        (epc_next),
    .misaligned_next (misaligned_next)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= BOOT;
      pc_q         <= RESET_ADDR;
      epc_q        <= '0;
      pc_valid_q   <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state        <= state_next;
      pc_q         <= pc_next;
      epc_q        <= epc_next;
      pc_valid_q   <= (state_next == RUN);
      misaligned_q <= misaligned_next;
    end
  end

  assign bus.Pc_reg     = pc_q;
  assign bus.Pc_valid   = pc_valid_q;
  assign bus.Epc        = epc_q;
  assign bus.Misaligned = misaligned_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed + random checks of pc_sequencer against a fetch-behaviour model.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst8 = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.WIDTH(32)) bus ();
  pc_sequencer_if #(.WIDTH(8))  bus8 ();

  pc_sequencer #(
    .WIDTH(32), .RESET_ADDR(32'h0), .TRAP_VECTOR(32'h80), .INSTR_BYTES(4)
  ) dut (.Clock(clk), .Reset(rst), .bus(bus));

  pc_sequencer #(
    .WIDTH(8), .RESET_ADDR(8'hF0), .TRAP_VECTOR(32'h80), .INSTR_BYTES(4)
  ) dut8 (.Clock(clk), .Reset(rst8), .bus(bus8));

  // Model: booting = one dead cycle after reset, bubble = one dead cycle after a control change.
  logic [31:0] m_pc, m_epc;
  logic        m_valid, m_mis, m_booting, m_bubble;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic s, input logic rv, input logic [31:0] ra,
                       input logic t, input logic tr, input logic r);
    m_mis = 1'b0;
    if (r) begin
      m_booting = 1'b1; m_bubble = 1'b0; m_pc = 32'h0; m_epc = 32'h0;
    end else if (m_booting) begin
      m_booting = 1'b0;
    end else if (t) begin
      m_epc = m_pc; m_pc = 32'h80; m_bubble = 1'b1;
    end else if (tr) begin
      m_pc = m_epc; m_bubble = 1'b1;
    end else if (rv && (ra % 4) != 0) begin
      m_epc = ra; m_pc = 32'h80; m_mis = 1'b1; m_bubble = 1'b1;
    end else if (rv) begin
      m_pc = ra; m_bubble = 1'b1;
    end else if (m_bubble) begin
      m_bubble = 1'b0;
    end else if (!s) begin
      m_pc = m_pc + 32'd4;
    end
    m_valid = !(m_booting || m_bubble);
  endtask

  task automatic step(input logic s, input logic rv, input logic [31:0] ra,
                      input logic t, input logic tr, input logic r);
    bus.Stall = s; bus.Redirect_valid = rv; bus.Redirect_addr = ra;
    bus.Trap = t; bus.Trap_return = tr; rst = r;
    @(posedge clk);
    model(s, rv, ra, t, tr, r);
    #1;
    chk("pc", bus.Pc_reg, m_pc);
    chk("pc_valid", 32'(bus.Pc_valid), 32'(m_valid));
    chk("epc", bus.Epc, m_epc);
    chk("misaligned", 32'(bus.Misaligned), 32'(m_mis));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] ra;
    bus8.Stall = 1'b0; bus8.Redirect_valid = 1'b0; bus8.Redirect_addr = 8'h0;
    bus8.Trap = 1'b0; bus8.Trap_return = 1'b0;

    // Reset and boot
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    chk("rst_pc", bus.Pc_reg, 32'h0);
    chk("rst_valid", 32'(bus.Pc_valid), 32'h0);
    idle();
    chk("boot_pc0", bus.Pc_reg, 32'h0);
    chk("boot_valid", 32'(bus.Pc_valid), 32'h1);
    idle(); idle(); idle();
    chk("seq_pc12", bus.Pc_reg, 32'hC);
    idle();

    // Stall at 0x10
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("stall_pc", bus.Pc_reg, 32'h10);
    chk("stall_valid", 32'(bus.Pc_valid), 32'h1);
    idle();
    chk("unstall_pc", bus.Pc_reg, 32'h14);
    idle(); idle(); idle();

    // Redirect at 0x20
    step(1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    chk("redir_pc", bus.Pc_reg, 32'h200);
    chk("redir_bubble", 32'(bus.Pc_valid), 32'h0);
    idle();
    idle();
    chk("redir_next", bus.Pc_reg, 32'h204);

    // Trap at 0x40, then return
    step(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    idle();
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("trap_pc", bus.Pc_reg, 32'h80);
    chk("trap_epc", bus.Epc, 32'h40);
    idle(); idle();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("tret_pc", bus.Pc_reg, 32'h40);
    idle();
    chk("tret_valid", 32'(bus.Pc_valid), 32'h1);

    // Misaligned redirect, then trap+redirect together
    step(1'b0, 1'b1, 32'h202, 1'b0, 1'b0, 1'b0);
    chk("mis_flag", 32'(bus.Misaligned), 32'h1);
    chk("mis_epc", bus.Epc, 32'h202);
    chk("mis_pc", bus.Pc_reg, 32'h80);
    idle();
    chk("mis_pulse", 32'(bus.Misaligned), 32'h0);
    step(1'b0, 1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
    chk("trap_wins", bus.Pc_reg, 32'h80);
    idle(); idle();
    chk("redir_dropped", bus.Pc_reg, 32'h84);

    // Retarget during FLUSH, then reset during FLUSH
    step(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h180, 1'b0, 1'b0, 1'b0);
    idle();
    chk("flush_retarget", bus.Pc_reg, 32'h180);
    step(1'b0, 1'b1, 32'h500, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h600, 1'b1, 1'b0, 1'b1);
    chk("flush_rst_pc", bus.Pc_reg, 32'h0);
    chk("flush_rst_valid", 32'(bus.Pc_valid), 32'h0);
    chk("flush_rst_epc", bus.Epc, 32'h0);
    idle();

    // 8-bit instance wraps 0xFC -> 0x00
    rst8 = 1'b1;
    idle();
    chk("w8_rst", 32'(bus8.Pc_reg), 32'hF0);
    rst8 = 1'b0;
    repeat (4) idle();
    chk("w8_fc", 32'(bus8.Pc_reg), 32'hFC);
    idle();
    chk("w8_wrap", 32'(bus8.Pc_reg), 32'h00);
    chk("w8_valid", 32'(bus8.Pc_valid), 32'h1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      ra = $urandom;
      if ($urandom_range(3) != 0) ra[1:0] = 2'b00;
      step(($urandom_range(9) < 3), ($urandom_range(9) == 0), ra,
           ($urandom_range(29) == 0), ($urandom_range(29) == 0),
           ($urandom_range(63) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter unit for the fetch stage; successor to the single-register PC. Holds the fetch address, increments it each cycle, and handles stall, branch/jump redirect, trap entry with saved exception PC, trap return and misaligned-target detection. A small state machine inserts one-cycle bubbles after boot and after every control-flow change, so instruction memory sees only valid addresses.

## Interface
- WIDTH, 32: address width in bits.
- RESET_ADDR, 0: fetch address after reset.
- TRAP_VECTOR, 32'h0000_0080: trap handler entry address (truncated to WIDTH).
- INSTR_BYTES, 4: increment step; power of two ≥ 1; alignment unit.

- Clock  in  1  single clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Stall  in  1  hold the current PC (RUN only).
- Redirect_valid  in  1  branch/jump taken this cycle.
- Redirect_addr  in  WIDTH  branch/jump target.
- Trap  in  1  exception request.
- Trap_return  in  1  return to Epc.
- Pc_reg  out  WIDTH  current fetch address.
- Pc_valid  out  1  Pc_reg is a real fetch this cycle.
- Epc  out  WIDTH  saved exception PC.
- Misaligned  out  1  one-cycle pulse: rejected misaligned redirect.

## Operation
- States: BOOT, RUN, FLUSH.
- Reset (sampled at the rising edge): state=BOOT, Pc_reg=RESET_ADDR, Epc=0, Pc_valid=0, Misaligned=0. Reset wins over every other input, including mid-trap or mid-flush.
- BOOT: all inputs ignored; next state RUN; Pc_reg unchanged.
- RUN and FLUSH evaluate events in strict priority order:
  1. Trap: Epc<=Pc_reg; Pc_reg<=TRAP_VECTOR; next state FLUSH.
  2. Trap_return: Pc_reg<=Epc; next state FLUSH.
  3. Redirect_valid with Redirect_addr[log2(INSTR_BYTES)-1:0]!=0 (misaligned): Epc<=Redirect_addr; Pc_reg<=TRAP_VECTOR; Misaligned=1 for the next cycle; next state FLUSH.
  4. Redirect_valid, aligned: Pc_reg<=Redirect_addr; next state FLUSH.
  5. None of the above, RUN, Stall=1: Pc_reg held; stay in RUN.
  6. None of the above, RUN, Stall=0: Pc_reg<=Pc_reg+INSTR_BYTES, modulo 2^WIDTH (wraps silently, no flag); stay in RUN.
  7. None of the above, FLUSH: Pc_reg held; next state RUN. Stall is ignored in FLUSH.
- Pc_valid=1 only in RUN. It is a registered state decode.
- Epc changes only on Trap or on a misaligned redirect.

## Timing
- All outputs are registered. Each one updates on the edge after its inputs are sampled.
- Reset deasserted at edge N: BOOT during cycle N+1; RUN with Pc_reg=RESET_ADDR, Pc_valid=1 at cycle N+2.
- Redirect/trap/trap-return sampled at edge N: new Pc_reg and Pc_valid=0 at N+1; Pc_valid=1 with the same Pc_reg at N+2. The fetch of the target address therefore follows a one-cycle bubble.
- An event in FLUSH retargets immediately and extends FLUSH by one cycle.
- Trap in the same cycle as Redirect or Trap_return: Trap wins, and the other input is dropped.
- Misaligned is high for exactly one cycle per rejected redirect.

## Structure
- Package pc_pkg: state enum (BOOT, RUN, FLUSH) and the alignment-mask localparam derived from INSTR_BYTES.
- One combinational sub-module, pc_next_sel: priority mux that produces the next Pc_reg, next Epc, next state and the misaligned flag. The top level holds only the registers.

## Test plan
- Reset, then release with Stall=0: Pc_valid=0 for one cycle, then Pc_reg=0,4,8,12 on consecutive cycles with Pc_valid=1.
- Stall=1 for 3 cycles at Pc_reg=0x10: Pc_reg stays 0x10 and Pc_valid stays 1; after release, 0x14.
- Redirect to 0x200 at Pc_reg=0x20: next cycle Pc_reg=0x200, Pc_valid=0; then 0x200 valid, then 0x204.
- Trap at 0x40, then Trap_return later: Epc=0x40 and Pc_reg=0x80 after one bubble; return gives 0x40 after one bubble.
- Redirect to 0x202 (misaligned): Misaligned pulses once, Epc=0x202, Pc_reg=0x80. Trap and Redirect asserted together: Pc_reg=0x80 and the redirect is dropped.
- WIDTH=8 at Pc_reg=0xFC, no stall: next value 0x00. Reset asserted during FLUSH: next cycle Pc_reg=RESET_ADDR, state BOOT.
